// File: rtl/patch_writer_pkg.sv
// Shared constants and FSM state type for the patch writer.
// Optional build macro: PATCH_ZERO_PAD_EN (store pixels flagged invalid as zero).
package lk_patch_pkg;

   localparam int PR_DEF    = 16;
   localparam int PC_DEF    = 16;
   localparam int PIX_W_DEF = 8;

   localparam int R_DEF     = 2 * PR_DEF + 1;
   localparam int C_DEF     = 2 * PC_DEF + 1;
   localparam int DEPTH_DEF = R_DEF * C_DEF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      FULL = 2'd2
   } state_t;

endpackage

// File: rtl/patch_writer_if.sv
// Pixel-stream, patch-status and read-port bundle between a producer/consumer and the patch writer.
// Handshake: a pixel transfers on every clock where pix_valid && pix_ready; pix_ready is high only while filling.
interface patch_writer_if
   import lk_patch_pkg::*;
#(
   parameter int PR    = PR_DEF,
   parameter int PC    = PC_DEF,
   parameter int PIX_W = PIX_W_DEF
);
   localparam int R     = 2 * PR + 1;
   localparam int C     = 2 * PC + 1;
   localparam int DEPTH = R * C;
   localparam int AW    = $clog2(DEPTH);
   localparam int RW    = $clog2(R);
   localparam int CW    = $clog2(C);

   logic             start;
   logic             pix_valid;
   logic [PIX_W-1:0] pix_data;
   logic             pix_invalid;
   logic             pix_ready;
   logic [AW:0]      pix_count;
   logic             patch_ready;
   // "release" is a reserved word, hence the suffix.
   logic             release_req;
   logic             rd_en;
   logic [RW-1:0]    rd_row;
   logic [CW-1:0]    rd_col;
   logic [PIX_W-1:0] rd_data;
   logic             rd_valid;
   logic             rd_err;

   modport master (
      output start, pix_valid, pix_data, pix_invalid, release_req,
      output rd_en, rd_row, rd_col,
      input  pix_ready, pix_count, patch_ready, rd_data, rd_valid, rd_err
   );

   modport slave (
      input  start, pix_valid, pix_data, pix_invalid, release_req,
      input  rd_en, rd_row, rd_col,
      output pix_ready, pix_count, patch_ready, rd_data, rd_valid, rd_err
   );

endinterface

// File: rtl/patch_writer_ram.sv
// Simple dual-port patch storage: synchronous write port, registered one-cycle read port.
module patch_ram
   import lk_patch_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int PIX_W = PIX_W_DEF,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [PIX_W-1:0] i_wdata,
   input  logic             i_re,
   input  logic [AW-1:0]    i_raddr,
   output logic [PIX_W-1:0] o_rdata
);

   logic [PIX_W-1:0] r_mem [DEPTH];
   logic [PIX_W-1:0] r_rdata;

   // No reset on the array: contents survive a reset of the control logic.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/patch_writer.sv
// Captures an R x C pixel patch in row-major order and serves random-access reads once full.
// Build macro PATCH_ZERO_PAD_EN: pixels written with pix_invalid=1 are stored as zero.
module patch_writer
   import lk_patch_pkg::*;
#(
   parameter int PR    = PR_DEF,
   parameter int PC    = PC_DEF,
   parameter int PIX_W = PIX_W_DEF
) (
   input  logic           clk,
   input  logic           reset,
   patch_writer_if.slave  bus,
   output state_t         o_state
);

   localparam int R     = 2 * PR + 1;
   localparam int C     = 2 * PC + 1;
   localparam int DEPTH = R * C;
   localparam int AW    = $clog2(DEPTH);
   localparam int RW    = $clog2(R);
   localparam int CW    = $clog2(C);
   localparam int CNT_W = AW + 1;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [RW-1:0]    r_row;
   logic [RW-1:0]    w_row_nxt;
   logic [CW-1:0]    r_col;
   logic [CW-1:0]    w_col_nxt;
   logic [AW-1:0]    r_wr_addr;
   logic [AW-1:0]    w_wr_addr_nxt;
   logic [CNT_W-1:0] r_pix_count;
   logic [CNT_W-1:0] w_pix_count_nxt;
   logic             w_wr_en;
   logic [PIX_W-1:0] w_wr_data;

   logic             w_rd_in_range;
   logic [AW-1:0]    w_rd_addr;
   logic [PIX_W-1:0] w_ram_q;
   logic             r_rd_valid;
   logic             r_rd_err;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_row       <= '0;
         r_col       <= '0;
         r_wr_addr   <= '0;
         r_pix_count <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_row       <= w_row_nxt;
         r_col       <= w_col_nxt;
         r_wr_addr   <= w_wr_addr_nxt;
         r_pix_count <= w_pix_count_nxt;
      end
   end

   // A start seen in IDLE or FILL always re-arms the counters; in FILL it also drops that cycle's pixel.
   always_comb begin
      w_state_nxt     = r_state;
      w_row_nxt       = r_row;
      w_col_nxt       = r_col;
      w_wr_addr_nxt   = r_wr_addr;
      w_pix_count_nxt = r_pix_count;
      w_wr_en         = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_state_nxt     = FILL;
               w_row_nxt       = '0;
               w_col_nxt       = '0;
               w_wr_addr_nxt   = '0;
               w_pix_count_nxt = '0;
            end
         end
         FILL: begin
            if (bus.start) begin
               w_row_nxt       = '0;
               w_col_nxt       = '0;
               w_wr_addr_nxt   = '0;
               w_pix_count_nxt = '0;
            end else if (bus.pix_valid) begin
               w_wr_en       = 1'b1;
               w_wr_addr_nxt = r_wr_addr + AW'(1);
               if (r_pix_count != CNT_W'(DEPTH)) begin
                  w_pix_count_nxt = r_pix_count + CNT_W'(1);
               end
               if (r_col == CW'(C - 1)) begin
                  w_col_nxt = '0;
                  if (r_row == RW'(R - 1)) begin
                     w_state_nxt = FULL;
                  end else begin
                     w_row_nxt = r_row + RW'(1);
                  end
               end else begin
                  w_col_nxt = r_col + CW'(1);
               end
            end
         end
         FULL: begin
            if (bus.release_req) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

`ifdef PATCH_ZERO_PAD_EN
   assign w_wr_data = bus.pix_invalid ? '0 : bus.pix_data;
`else
   logic w_unused_invalid;
   assign w_unused_invalid = bus.pix_invalid;
   assign w_wr_data        = bus.pix_data;
`endif

   assign w_rd_in_range = (bus.rd_row < RW'(R)) && (bus.rd_col < CW'(C));
   assign w_rd_addr     = AW'(bus.rd_row) * AW'(C) + AW'(bus.rd_col);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd_valid <= 1'b0;
         r_rd_err   <= 1'b0;
      end else begin
         r_rd_valid <= bus.rd_en && w_rd_in_range && (r_state == FULL);
         r_rd_err   <= bus.rd_en && !w_rd_in_range;
      end
   end

   patch_ram #(
      .DEPTH (DEPTH),
      .PIX_W (PIX_W),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_wr_en),
      .i_waddr (r_wr_addr),
      .i_wdata (w_wr_data),
      .i_re    (bus.rd_en && w_rd_in_range),
      .i_raddr (w_rd_addr),
      .o_rdata (w_ram_q)
   );

   // Gating with rd_valid gives zero for out-of-range reads and right after reset.
   assign bus.rd_data     = r_rd_valid ? w_ram_q : '0;
   assign bus.rd_valid    = r_rd_valid;
   assign bus.rd_err      = r_rd_err;
   assign bus.pix_ready   = (r_state == FILL);
   assign bus.patch_ready = (r_state == FULL);
   assign bus.pix_count   = r_pix_count;
   assign o_state         = r_state;

endmodule
